elevator_scan_ctrl: RTL and testbench

//  Parametrised N-floor elevator controller with SCAN (directional-sweep) scheduling.
//  - Latches one-cycle request pulses into a pending vector and serves them in sweep order.
//  - Applies configurable floor-to-floor travel time and door-open dwell time.
//  - Drives the car status outputs (floor, moving, door, direction) for the cabin/display logic.

---
 rtl/elev_pkg.sv | 13 +
 rtl/elev_req_scan.sv | 34 +++
 rtl/elevator_scan_ctrl.sv | 164 ++++++++++++++++
 tb/tb_elevator_scan_ctrl.sv | 285 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/elev_pkg.sv
// Shared types for the SCAN elevator controller: FSM state encoding and sweep direction values.
package elev_pkg;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_MOVE,
        ST_DOOR
    } state_t;

    localparam logic DIR_UP   = 1'b1;
    localparam logic DIR_DOWN = 1'b0;

endpackage

// File: rtl/elev_req_scan.sv
// Combinational request scanner: reports pending requests above, below and at the car floor.
module elev_req_scan
    import elev_pkg::*;
#(
    parameter int NUM_FLOORS = 8,
    parameter int FLOOR_W    = $clog2(NUM_FLOORS)
) (
    input  logic [NUM_FLOORS-1:0] pending,
    input  logic [FLOOR_W-1:0]    floor,
    output logic                  any_above,
    output logic                  any_below,
    output logic                  here
);

    logic [NUM_FLOORS-1:0] above_m;
    logic [NUM_FLOORS-1:0] below_m;
    logic [NUM_FLOORS-1:0] here_m;

    always_comb begin
        above_m = '0;
        below_m = '0;
        here_m  = '0;
        for (int i = 0; i < NUM_FLOORS; i++) begin
            above_m[i] = (FLOOR_W'(i) > floor);
            below_m[i] = (FLOOR_W'(i) < floor);
            here_m[i]  = (FLOOR_W'(i) == floor);
        end
    end

    assign any_above = |(pending & above_m);
    assign any_below = |(pending & below_m);
    assign here      = |(pending & here_m);

endmodule

// File: rtl/elevator_scan_ctrl.sv
// N-floor elevator controller with SCAN scheduling, travel/door timers and latched requests.
// Optional emergency-stop input is enabled by defining ELEV_ESTOP_EN.
module elevator_scan_ctrl
    import elev_pkg::*;
#(
    parameter int NUM_FLOORS    = 8,
    parameter int FLOOR_W       = $clog2(NUM_FLOORS),
    parameter int TRAVEL_CYCLES = 4,
    parameter int DOOR_CYCLES   = 6
) (
    input  logic                  clk,
    input  logic                  reset_n,
`ifdef ELEV_ESTOP_EN
    input  logic                  estop,
`endif
    input  logic [NUM_FLOORS-1:0] req,
    output logic [FLOOR_W-1:0]    floor,
    output logic                  moving,
    output logic                  door,
    output logic                  direction,
    output logic [NUM_FLOORS-1:0] pending,
    output logic                  arrive
);

    localparam int TCW = (TRAVEL_CYCLES > 1) ? $clog2(TRAVEL_CYCLES) : 1;
    localparam int DCW = (DOOR_CYCLES > 1) ? $clog2(DOOR_CYCLES) : 1;
    localparam logic [TCW-1:0] TCNT_LOAD = TCW'(TRAVEL_CYCLES - 1);
    localparam logic [DCW-1:0] DCNT_LOAD = DCW'(DOOR_CYCLES - 1);

    function automatic logic [NUM_FLOORS-1:0] onehot(input logic [FLOOR_W-1:0] f);
        logic [NUM_FLOORS-1:0] v;
        v = '0;
        for (int i = 0; i < NUM_FLOORS; i++) begin
            v[i] = (FLOOR_W'(i) == f);
        end
        return v;
    endfunction

    state_t                state_q, state_nx;
    logic [TCW-1:0]        tcnt_q, tcnt_nx;
    logic [DCW-1:0]        dcnt_q, dcnt_nx;
    logic [FLOOR_W-1:0]    floor_nx;
    logic                  moving_nx, door_nx, dir_nx, arrive_nx;
    logic [NUM_FLOORS-1:0] pending_nx;
    logic [NUM_FLOORS-1:0] served;
    logic [NUM_FLOORS-1:0] here_oh, step_oh;
    logic [FLOOR_W-1:0]    step_floor;
    logic                  any_above, any_below, here;
    logic                  halt;

`ifdef ELEV_ESTOP_EN
    assign halt = estop;
`else
    assign halt = 1'b0;
`endif

    elev_req_scan #(
        .NUM_FLOORS (NUM_FLOORS),
        .FLOOR_W    (FLOOR_W)
    ) u_scan (
        .pending   (pending),
        .floor     (floor),
        .any_above (any_above),
        .any_below (any_below),
        .here      (here)
    );

    assign step_floor = (direction == DIR_UP) ? floor + FLOOR_W'(1) : floor - FLOOR_W'(1);
    assign step_oh    = onehot(step_floor);
    assign here_oh    = onehot(floor);

    always_comb begin
        state_nx  = state_q;
        tcnt_nx   = tcnt_q;
        dcnt_nx   = dcnt_q;
        floor_nx  = floor;
        moving_nx = moving;
        door_nx   = door;
        dir_nx    = direction;
        arrive_nx = 1'b0;
        served    = '0;

        // A halted controller holds every timer and the floor; requests keep latching.
        if (halt) begin
            moving_nx = 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (here) begin
                        state_nx = ST_DOOR;
                        door_nx  = 1'b1;
                        dcnt_nx  = DCNT_LOAD;
                        served   = here_oh;
                    end else if (pending != '0) begin
                        dir_nx    = (any_above && (direction == DIR_UP || !any_below)) ? DIR_UP : DIR_DOWN;
                        state_nx  = ST_MOVE;
                        moving_nx = 1'b1;
                        tcnt_nx   = TCNT_LOAD;
                    end
                end
                ST_MOVE: begin
                    moving_nx = 1'b1;
                    if (tcnt_q == '0) begin
                        floor_nx  = step_floor;
                        arrive_nx = 1'b1;
                        // A request landing on the arrival edge still stops the car here.
                        if (((pending | req) & step_oh) != '0) begin
                            state_nx  = ST_DOOR;
                            moving_nx = 1'b0;
                            door_nx   = 1'b1;
                            dcnt_nx   = DCNT_LOAD;
                            served    = step_oh;
                        end else begin
                            tcnt_nx = TCNT_LOAD;
                        end
                    end else begin
                        tcnt_nx = tcnt_q - TCW'(1);
                    end
                end
                ST_DOOR: begin
                    served = here_oh;
                    if ((req & here_oh) != '0) begin
                        dcnt_nx = DCNT_LOAD;
                    end else if (dcnt_q == '0) begin
                        door_nx  = 1'b0;
                        state_nx = ST_IDLE;
                    end else begin
                        dcnt_nx = dcnt_q - DCW'(1);
                    end
                end
                default: begin
                    state_nx = ST_IDLE;
                end
            endcase
        end

        pending_nx = (pending | req) & ~served;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q   <= ST_IDLE;
            tcnt_q    <= '0;
            dcnt_q    <= '0;
            floor     <= '0;
            moving    <= 1'b0;
            door      <= 1'b0;
            direction <= DIR_UP;
            pending   <= '0;
            arrive    <= 1'b0;
        end else begin
            state_q   <= state_nx;
            tcnt_q    <= tcnt_nx;
            dcnt_q    <= dcnt_nx;
            floor     <= floor_nx;
            moving    <= moving_nx;
            door      <= door_nx;
            direction <= dir_nx;
            pending   <= pending_nx;
            arrive    <= arrive_nx;
        end
    end

endmodule

// File: tb/tb_elevator_scan_ctrl.sv
// Scoreboard bench for elevator_scan_ctrl: expected arrivals are queued by the stimulus and
// checked by a monitor on every arrive pulse; the estop scenario needs ELEV_ESTOP_EN.
module tb_elevator_scan_ctrl;

    localparam int N  = 8;
    localparam int FW = 3;
    localparam int T  = 4;
    localparam int D  = 6;

    logic          clk     = 1'b0;
    logic          reset_n = 1'b0;
    logic [N-1:0]  req     = '0;
    logic [FW-1:0] floor;
    logic          moving, door, direction, arrive;
    logic [N-1:0]  pending;
`ifdef ELEV_ESTOP_EN
    logic          estop = 1'b0;
`endif

    always #5 clk = ~clk;

    elevator_scan_ctrl #(
        .NUM_FLOORS    (N),
        .FLOOR_W       (FW),
        .TRAVEL_CYCLES (T),
        .DOOR_CYCLES   (D)
    ) dut (
        .clk       (clk),
        .reset_n   (reset_n),
`ifdef ELEV_ESTOP_EN
        .estop     (estop),
`endif
        .req       (req),
        .floor     (floor),
        .moving    (moving),
        .door      (door),
        .direction (direction),
        .pending   (pending),
        .arrive    (arrive)
    );

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic [FW-1:0] fl;
        logic          dr;
        logic          dir;
        int            at;
    } exp_t;

    exp_t sb[$];
    exp_t mon_e;
    int   checks   = 0;
    int   failures = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
        checks++;
        if (act !== expv) begin
            failures++;
            $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, expv, cyc);
        end
    endtask

    always @(negedge clk) begin
        if (reset_n) begin
            checks++;
            if (moving && door) begin
                failures++;
                $display("FAIL moving_door_excl: moving=%0b door=%0b, expected not both 1", moving, door);
            end
            if (arrive === 1'b1) begin
                if (sb.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL unexpected_arrive: floor=%0d at cycle %0d, expected no arrival", floor, cyc);
                end else begin
                    mon_e = sb.pop_front();
                    chk("arr_floor", 32'(floor), 32'(mon_e.fl));
                    chk("arr_door", 32'(door), 32'(mon_e.dr));
                    chk("arr_dir", 32'(direction), 32'(mon_e.dir));
                    chk("arr_cycle", 32'(cyc), 32'(mon_e.at));
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_to(input int n);
        while (cyc < n) tick();
    endtask

    task automatic pulse(input logic [N-1:0] r);
        req = r;
        tick();
        req = '0;
    endtask

    task automatic push_one(input int fl, input logic dr, input logic dir, input int at);
        exp_t e;
        e.fl  = FW'(fl);
        e.dr  = dr;
        e.dir = dir;
        e.at  = at;
        sb.push_back(e);
    endtask

    // One sweep: a floor passes every T clocks from the move-entry edge; door opens at the last one if stop.
    task automatic push_run(input int mentry, input int from, input int to, input logic stop,
                            output int last_at);
        logic dirv;
        int   steps;
        dirv  = (to > from);
        steps = dirv ? to - from : from - to;
        for (int j = 1; j <= steps; j++) begin
            push_one(dirv ? from + j : from - j, stop && (j == steps), dirv, mentry + T * j);
        end
        last_at = mentry + T * steps;
    endtask

    task automatic drain(input int limit);
        int k = 0;
        while (sb.size() != 0 && k < limit) begin
            tick();
            k++;
        end
        checks++;
        if (sb.size() != 0) begin
            failures++;
            $display("FAIL drain_timeout: %0d arrivals outstanding, expected 0", sb.size());
            sb.delete();
        end
    endtask

    task automatic chk_reset_vals(input string tag);
        chk({tag, "_floor"}, 32'(floor), 32'd0);
        chk({tag, "_moving"}, 32'(moving), 32'd0);
        chk({tag, "_door"}, 32'(door), 32'd0);
        chk({tag, "_dir"}, 32'(direction), 32'd1);
        chk({tag, "_pending"}, 32'(pending), 32'd0);
        chk({tag, "_arrive"}, 32'(arrive), 32'd0);
    endtask

    task automatic do_reset();
        reset_n = 1'b0;
        tick();
        tick();
        chk_reset_vals("rst");
        reset_n = 1'b1;
        tick();
    endtask

    initial begin
        #300000;
        $display("FAIL global_timeout: simulation did not finish, expected completion");
        $fatal(1, "timeout");
    end

    initial begin
        int c, a, a2, a3;

        // Scenario 1: single request two floors up
        do_reset();
        c = cyc;
        pulse(8'h04);
        push_run(c + 2, 0, 2, 1'b1, a);
        wait_to(a);
        chk("s1_door_open", 32'(door), 32'd1);
        chk("s1_floor", 32'(floor), 32'd2);
        chk("s1_pending", 32'(pending), 32'd0);
        wait_to(a + D - 1);
        chk("s1_door_last", 32'(door), 32'd1);
        wait_to(a + D);
        chk("s1_door_closed", 32'(door), 32'd0);
        drain(20);

        // Scenario 2: multi-hot request served in upward sweep order
        do_reset();
        c = cyc;
        pulse(8'h8A);
        chk("s2_pending_latched", 32'(pending), 32'h8A);
        push_run(c + 2, 0, 1, 1'b1, a);
        push_run(a + D + 1, 1, 3, 1'b1, a);
        push_run(a + D + 1, 3, 7, 1'b1, a);
        wait_to(a + D + 1);
        chk("s2_floor", 32'(floor), 32'd7);
        chk("s2_dir", 32'(direction), 32'd1);
        chk("s2_pending", 32'(pending), 32'd0);
        chk("s2_door", 32'(door), 32'd0);
        drain(20);

        // Scenario 3: at floor 5 heading up, requests 2 and 6 together -> 6 first, then reverse
        do_reset();
        c = cyc;
        pulse(8'h20);
        push_run(c + 2, 0, 5, 1'b1, a);
        wait_to(a + D + 2);
        chk("s3_idle_door", 32'(door), 32'd0);
        chk("s3_idle_dir", 32'(direction), 32'd1);
        c = cyc;
        pulse(8'h44);
        push_run(c + 2, 5, 6, 1'b1, a2);
        push_run(a2 + D + 1, 6, 2, 1'b1, a3);
        wait_to(a2 + 1);
        chk("s3_pending_after6", 32'(pending), 32'h04);
        wait_to(a3);
        chk("s3_dir_down", 32'(direction), 32'd0);
        chk("s3_floor", 32'(floor), 32'd2);
        chk("s3_pending", 32'(pending), 32'd0);
        drain(20);
        wait_to(a3 + D + 1);

        // Scenario 4: repeated request for the open-door floor restarts the door timer
        do_reset();
        c = cyc;
        pulse(8'h08);
        push_run(c + 2, 0, 3, 1'b1, a);
        wait_to(a + 2);
        pulse(8'h08);
        chk("s4_pending_absorb1", 32'(pending), 32'd0);
        wait_to(a + 4);
        pulse(8'h08);
        chk("s4_pending_absorb2", 32'(pending), 32'd0);
        wait_to(a + 10);
        chk("s4_door_extended", 32'(door), 32'd1);
        wait_to(a + 11);
        chk("s4_door_closed", 32'(door), 32'd0);
        wait_to(a + 14);
        chk("s4_stays_closed", 32'(door), 32'd0);
        chk("s4_not_moving", 32'(moving), 32'd0);
        chk("s4_floor", 32'(floor), 32'd3);
        chk("s4_pending_end", 32'(pending), 32'd0);
        drain(5);

        // Scenario 5: asynchronous reset while travelling between floors 4 and 5
        do_reset();
        c = cyc;
        pulse(8'h80);
        push_run(c + 2, 0, 4, 1'b0, a);
        wait_to(a + 1);
        chk("s5_floor_before", 32'(floor), 32'd4);
        chk("s5_moving_before", 32'(moving), 32'd1);
        #2;
        reset_n = 1'b0;
        #1;
        chk_reset_vals("s5_async");
        tick();
        tick();
        reset_n = 1'b1;
        repeat (8) tick();
        chk("s5_after_floor", 32'(floor), 32'd0);
        chk("s5_after_moving", 32'(moving), 32'd0);
        chk("s5_after_pending", 32'(pending), 32'd0);
        drain(5);

`ifdef ELEV_ESTOP_EN
        // Scenario 6: estop for 10 clocks mid-move delays the next arrival by exactly 10
        do_reset();
        c = cyc;
        pulse(8'h04);
        push_run(c + 2, 0, 1, 1'b0, a);
        push_one(2, 1'b1, 1'b1, c + 20);
        wait_to(c + 7);
        estop = 1'b1;
        wait_to(c + 9);
        chk("s6_frozen_moving", 32'(moving), 32'd0);
        chk("s6_frozen_floor", 32'(floor), 32'd1);
        chk("s6_frozen_door", 32'(door), 32'd0);
        wait_to(c + 17);
        estop = 1'b0;
        wait_to(c + 18);
        chk("s6_resume_moving", 32'(moving), 32'd1);
        chk("s6_resume_floor", 32'(floor), 32'd1);
        drain(20);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
